// File: rtl/rom_arb_pkg.sv
// ============================================================================
// Module      : rom_arb_pkg
// Description : Shared widths, index-width helper and tag type for the
//               dual-port ROM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

    localparam int c_rom_addr_w = 4;
    localparam int c_rom_data_w = 4;
    localparam int c_max_req    = 8;
    localparam int c_tag_idx_w  = 3;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [c_tag_idx_w-1:0] idx;
    } tag_t;

endpackage

`default_nettype wire

// File: rtl/rom_arb_pick2.sv
// ============================================================================
// Module      : rom_arb_pick2
// Description : Combinational two-winner round-robin picker (ports A and B).
//               ROM_ARB_PRIO_EN: requester 0 owns port A whenever it asks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arb_pick2
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant_a,
    output logic [NUM_REQ-1:0] grant_b,
    output logic               grant_a_vld,
    output logic               grant_b_vld
);

    localparam int c_sum_w = IDX_W + 1;

    logic [c_sum_w-1:0] w_sum;
    logic [IDX_W-1:0]   w_idx;

    always_comb begin
        grant_a     = '0;
        grant_b     = '0;
        grant_a_vld = 1'b0;
        grant_b_vld = 1'b0;
        w_sum       = '0;
        w_idx       = '0;
`ifdef ROM_ARB_PRIO_EN
        if (req[0]) begin
            grant_a[0]  = 1'b1;
            grant_a_vld = 1'b1;
        end
`endif
        // Walk all requesters once, starting at rr_ptr and wrapping.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, rr_ptr} + c_sum_w'(k);
            if (w_sum >= c_sum_w'(NUM_REQ)) begin
                w_sum = w_sum - c_sum_w'(NUM_REQ);
            end
            w_idx = w_sum[IDX_W-1:0];
`ifdef ROM_ARB_PRIO_EN
            if (req[w_idx] && (w_idx != '0)) begin
`else
            if (req[w_idx]) begin
`endif
                if (!grant_a_vld) begin
                    grant_a[w_idx] = 1'b1;
                    grant_a_vld    = 1'b1;
                end else if (!grant_b_vld) begin
                    grant_b[w_idx] = 1'b1;
                    grant_b_vld    = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// ============================================================================
// Module      : rom_port_arbiter
// Description : Shares the two read ports of a 16x4 registered dual-port ROM
//               among NUM_REQ requesters; fixed 2-cycle response latency.
//               ROM_ARB_PRIO_EN selects strict priority for requester 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = c_rom_addr_w,
    parameter int DATA_W  = c_rom_data_w
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [NUM_REQ*DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0]         rom_a_addr,
    output logic [ADDR_W-1:0]         rom_b_addr,
    input  logic [DATA_W-1:0]         rom_dout_a,
    input  logic [DATA_W-1:0]         rom_dout_b
);

    localparam int c_idx_w = idx_width(NUM_REQ);

    logic [c_idx_w-1:0]        r_rr_ptr;
    logic [c_idx_w-1:0]        w_rr_next;
    logic [NUM_REQ-1:0]        w_req;
    logic [NUM_REQ-1:0]        w_grant_a;
    logic [NUM_REQ-1:0]        w_grant_b;
    logic                      w_grant_a_vld;
    logic                      w_grant_b_vld;
    logic [c_idx_w-1:0]        w_idx_a;
    logic [c_idx_w-1:0]        w_idx_b;
    logic [c_idx_w-1:0]        w_last;
    logic                      w_adv;
    tag_t                      r_tag_s1_a;
    tag_t                      r_tag_s1_b;
    tag_t                      r_tag_s2_a;
    tag_t                      r_tag_s2_b;
    logic [NUM_REQ*DATA_W-1:0] r_rsp_data;

    // Masking requests with rst_n keeps ready and ROM addresses at 0 in reset.
    assign w_req = req_valid & {NUM_REQ{rst_n}};

    rom_arb_pick2 #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_pick2 (
        .req         (w_req),
        .rr_ptr      (r_rr_ptr),
        .grant_a     (w_grant_a),
        .grant_b     (w_grant_b),
        .grant_a_vld (w_grant_a_vld),
        .grant_b_vld (w_grant_b_vld)
    );

    assign req_ready = w_grant_a | w_grant_b;

    always_comb begin
        w_idx_a    = '0;
        w_idx_b    = '0;
        rom_a_addr = '0;
        rom_b_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_a[i]) begin
                w_idx_a    = c_idx_w'(i);
                rom_a_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
            if (w_grant_b[i]) begin
                w_idx_b    = c_idx_w'(i);
                rom_b_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Port B is always the later winner in scan order, so it sets the pointer.
    always_comb begin
        w_last = w_grant_b_vld ? w_idx_b : w_idx_a;
`ifdef ROM_ARB_PRIO_EN
        w_adv  = w_grant_b_vld || (w_grant_a_vld && (w_idx_a != '0));
`else
        w_adv  = w_grant_a_vld;
`endif
        w_rr_next = r_rr_ptr;
        if (w_adv) begin
            w_rr_next = (w_last == c_idx_w'(NUM_REQ - 1)) ? '0 : w_last + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else begin
            r_rr_ptr <= w_rr_next;
        end
    end

    // Stage 1 is valid while the ROM presents the data; stage 2 marks the
    // cycle in which the registered response is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_s1_a <= '0;
            r_tag_s1_b <= '0;
            r_tag_s2_a <= '0;
            r_tag_s2_b <= '0;
            r_rsp_data <= '0;
        end else begin
            r_tag_s1_a <= '{valid: w_grant_a_vld, idx: c_tag_idx_w'(w_idx_a)};
            r_tag_s1_b <= '{valid: w_grant_b_vld, idx: c_tag_idx_w'(w_idx_b)};
            r_tag_s2_a <= r_tag_s1_a;
            r_tag_s2_b <= r_tag_s1_b;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (r_tag_s1_a.valid && (r_tag_s1_a.idx == c_tag_idx_w'(i))) begin
                    r_rsp_data[i*DATA_W +: DATA_W] <= rom_dout_a;
                end
                if (r_tag_s1_b.valid && (r_tag_s1_b.idx == c_tag_idx_w'(i))) begin
                    r_rsp_data[i*DATA_W +: DATA_W] <= rom_dout_b;
                end
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (r_tag_s2_a.valid && (r_tag_s2_a.idx == c_tag_idx_w'(i))) ||
                           (r_tag_s2_b.valid && (r_tag_s2_b.idx == c_tag_idx_w'(i)));
        end
    end

    assign rsp_data = r_rsp_data;

endmodule

`default_nettype wire
